// File: rtl/dbg_run_ctrl_if.sv
// dbg_run_ctrl_if: run-control strobes, config and status between the JTAG debug path and the sequencer
interface dbg_run_ctrl_if #(parameter int STEP_W = 8, parameter int CYC_W = 16);
  logic              halt_stb;
  logic              step_stb;
  logic              resume_stb;
  logic [STEP_W-1:0] step_count;
  logic [CYC_W-1:0]  cyc_limit;
  logic              bkpt_en;
  logic              bkpt_hit;
  logic              clk_en;
  logic              halted;
  logic [2:0]        halt_cause;
  logic [CYC_W-1:0]  cycle_cnt;
  modport master (
    output halt_stb, step_stb, resume_stb, step_count, cyc_limit, bkpt_en, bkpt_hit,
    input  clk_en, halted, halt_cause, cycle_cnt
  );
  modport slave (
    input  halt_stb, step_stb, resume_stb, step_count, cyc_limit, bkpt_en, bkpt_hit,
    output clk_en, halted, halt_cause, cycle_cnt
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: debug run-control sequencer driving the gated debug clock enable.
// Breakpoint halting and the skip flag exist only when DBG_BKPT_EN is defined.
module dbg_run_ctrl #(
  parameter int STEP_W = 8,
  parameter int CYC_W  = 16
) (
  input  logic          sys_clk,
  input  logic          dbg_rst,
  dbg_run_ctrl_if.slave bus
);
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [2:0] C_JTAG = 3'd1;
  localparam logic [2:0] C_STEP = 3'd2;
  localparam logic [2:0] C_BKPT = 3'd3;
  localparam logic [2:0] C_LIM  = 3'd4;

  logic [1:0]        state;
  logic [STEP_W-1:0] step_cnt;
  logic [CYC_W-1:0]  cyc_inc;
  logic              bkpt, lim_hit, step_done, halt_req, stop, go_step, go_run;
  logic [2:0]        cause_n;

`ifdef DBG_BKPT_EN
  logic skip;
  always_ff @(posedge sys_clk or negedge dbg_rst)
    if (!dbg_rst) skip <= 1'b0;
    else          skip <= (go_step || go_run) ? 1'b1 : bus.clk_en ? 1'b0 : skip;
  assign bkpt = bus.bkpt_en && bus.bkpt_hit && bus.clk_en && !skip;
`else
  logic unused_bkpt;
  assign unused_bkpt = bus.bkpt_en ^ bus.bkpt_hit;
  assign bkpt = 1'b0;
`endif

  // Stop conditions only arise outside HALT, so stop and the HALT exits never coincide
  always_comb begin
    cyc_inc   = bus.cycle_cnt + 1'b1;
    lim_hit   = (state == S_RUN) && (bus.cyc_limit != '0) && (cyc_inc == bus.cyc_limit);
    step_done = (state == S_STEP) && (step_cnt == STEP_W'(1));
    halt_req  = (state != S_HALT) && bus.halt_stb;
    stop      = halt_req || bkpt || lim_hit || step_done;
    go_step   = (state == S_HALT) && bus.step_stb;
    go_run    = (state == S_HALT) && !bus.step_stb && bus.resume_stb;
    cause_n   = halt_req ? C_JTAG : bkpt ? C_BKPT : lim_hit ? C_LIM : C_STEP;
  end

  always_ff @(posedge sys_clk or negedge dbg_rst)
    if (!dbg_rst) begin
      state          <= S_RUN;
      step_cnt       <= '0;
      bus.clk_en     <= 1'b1;
      bus.halted     <= 1'b0;
      bus.halt_cause <= 3'd0;
      bus.cycle_cnt  <= '0;
    end else begin
      bus.cycle_cnt <= bus.clk_en ? cyc_inc : (go_step || go_run) ? '0 : bus.cycle_cnt;
      step_cnt      <= go_step ? ((bus.step_count == '0) ? STEP_W'(1) : bus.step_count)
                     : (state == S_STEP) ? step_cnt - 1'b1 : step_cnt;
      if (stop) begin
        state          <= S_HALT;
        bus.clk_en     <= 1'b0;
        bus.halted     <= 1'b1;
        bus.halt_cause <= cause_n;
      end else if (go_step || go_run) begin
        state      <= go_step ? S_STEP : S_RUN;
        bus.clk_en <= 1'b1;
        bus.halted <= 1'b0;
      end
    end
endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Debug run-control sequencer in the sys_clk domain. Consumes the synchronized single-cycle halt/step/resume strobes from the JTAG debug path and sequences the gated debug clock enable: free run, halt, N-cycle step, cycle-limit halt and hardware-breakpoint halt. It reports halt status and cause for capture into a JTAG data register. It produces only `clk_en`. The existing negedge gate latch and AND stage form `dbg_clk` from it.

## Interface
- `STEP_W`, default 8: width of the step count.
- `CYC_W`, default 16: width of the enabled-cycle counter and the limit.

- `sys_clk` in 1: system clock; all state on posedge.
- `dbg_rst` in 1: reset, asynchronous, active-low; clock sys_clk.
- `halt_stb` in 1: one-cycle halt request.
- `step_stb` in 1: one-cycle step request.
- `resume_stb` in 1: one-cycle resume request.
- `step_count` in STEP_W: number of enabled cycles per step, sampled on the accepted `step_stb`.
- `cyc_limit` in CYC_W: run-cycle limit; 0 = no limit.
- `bkpt_en` in 1: breakpoint arm.
- `bkpt_hit` in 1: level from the core, qualified by `clk_en`.
- `clk_en` out 1: registered clock enable for the gate latch.
- `halted` out 1: registered, 1 in HALT.
- `halt_cause` out 3: 000 none, 001 jtag, 010 step done, 011 breakpoint, 100 limit.
- `cycle_cnt` out CYC_W: count of enabled cycles since the last step/resume.

## Operation
- Reset values: state RUN, `clk_en`=1, `halted`=0, `halt_cause`=000, `cycle_cnt`=0, skip=0, step counter=0.
- States:
  - RUN: `clk_en`=1.
  - HALT: `clk_en`=0.
  - STEP: `clk_en`=1 while the step counter is greater than 0.
- RUN → HALT:
  - on `halt_stb`, cause 001;
  - on a limit hit, cause 100;
  - on a breakpoint, cause 011.
  - `step_stb` and `resume_stb` are ignored in RUN.
- HALT → STEP: on `step_stb`. The step counter loads `step_count`; a value of 0 is treated as 1. `cycle_cnt` clears to 0 and skip is set.
- HALT → RUN: on `resume_stb`. `cycle_cnt` clears to 0 and skip is set.
- `halt_stb` in HALT is ignored. The cause is held.
- Strobe priority when strobes coincide: halt > step > resume. In HALT, step wins over resume.
- STEP:
  - The step counter decrements on each enabled cycle.
  - When the counter reaches 0, go to HALT with cause 010.
  - `halt_stb` aborts the step: go to HALT with cause 001.
  - A breakpoint ends the step early with cause 011.
  - `resume_stb` is ignored.
- `cycle_cnt` increments on every posedge where `clk_en`=1 and wraps modulo 2^CYC_W.
- Limit: in RUN with `cyc_limit`≠0, the edge at which the incremented `cycle_cnt` equals `cyc_limit` drops `clk_en`. Exactly `cyc_limit` enabled cycles follow a resume.
- Breakpoint: fires when `bkpt_en` && `bkpt_hit` && `clk_en` && !skip.
- Skip: clears after the first enabled cycle following step/resume. This lets the core move past the instruction that raised the breakpoint.
- Simultaneous events on one edge: priority is halt_stb > breakpoint > limit > step completion. The cause reflects the winner.
- `halted` and `halt_cause` retain their values until the next step/resume. `halt_cause` is not cleared on leaving HALT.

## Timing
- Strobe sampled at edge t → `clk_en` changes after edge t; the gate latch applies it on the following negedge.
- Step of N: `clk_en` is high for exactly N consecutive sys_clk cycles, then low. `halted` rises on the same edge that `clk_en` falls.
- Limit and breakpoint halts take effect on the same edge as the condition. There are no extra enabled cycles.
- Asynchronous reset forces the reset values immediately, including mid-step. Deassertion is synchronous to sys_clk by an upstream synchronizer.

## Configuration
- `DBG_BKPT_EN` defined: breakpoint logic and skip flag are present as specified.
- `DBG_BKPT_EN` undefined: `bkpt_en` and `bkpt_hit` are ignored, cause 011 is never produced, and the skip flag is removed. All other behaviour is identical.

## Test plan
- Reset, then run 5 cycles → `clk_en`=1, `cycle_cnt`=5, `halted`=0, `halt_cause`=000.
- `halt_stb`, then `step_stb` with `step_count`=3 → `clk_en` high for exactly 3 cycles, then `halted`=1, `halt_cause`=010, `cycle_cnt`=3. Repeat with `step_count`=0 → exactly 1 cycle.
- `cyc_limit`=10, halt, then `resume_stb` → exactly 10 enabled cycles, then `halt_cause`=100. Repeat with `cyc_limit`=0 → no halt after 300 cycles, and `cycle_cnt` wraps correctly with CYC_W=8.
- `DBG_BKPT_EN` defined, `bkpt_en`=1, `bkpt_hit` held 1:
  - in RUN → halt with cause 011 on the first edge;
  - resume → 1 enabled cycle (skip), then halt again with cause 011;
  - with `bkpt_hit` deasserted after the first cycle → run continues.
- `halt_stb` and `step_stb` on the same edge in RUN → HALT with cause 001, no step. `step_stb` and `resume_stb` together in HALT → STEP taken.
- `dbg_rst` asserted mid-step (step 2 of 5) → immediately `clk_en`=1, `halted`=0, `cycle_cnt`=0, state RUN.
